// File: rtl/servo_pkg.sv
// Shared servo timing defaults, FSM state type and pulse-length helper.
package servo_pkg;

    localparam int unsigned POS_W            = 8;
    localparam int unsigned FRAME_CYCLES_DEF = 1500000;
    localparam int unsigned PULSE_MIN_DEF    = 50000;
    localparam int unsigned PULSE_STEP_DEF   = 196;
    localparam int unsigned SLEW_STEP_DEF    = 4;
    localparam int unsigned RESET_POS_DEF    = 128;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } servo_state_e;

    // Pulse length at 32-bit width; 255 * step + min stays far below 2^32.
    function automatic int unsigned pulse_len(input logic [POS_W-1:0] pos,
                                              input int unsigned       min_c,
                                              input int unsigned       step_c);
        return min_c + 32'(pos) * step_c;
    endfunction

endpackage

// File: rtl/servo_slew_limiter.sv
// Moves cur toward target by at most step, never overshooting or wrapping.
module servo_slew_limiter
    import servo_pkg::*;
(
    input  logic [POS_W-1:0] cur,
    input  logic [POS_W-1:0] target,
    input  logic [POS_W-1:0] step,
    output logic [POS_W-1:0] next
);

    logic [POS_W:0] w_diff;
    logic [POS_W:0] w_mag;
    logic           w_neg;

    always_comb begin
        w_diff = {1'b0, target} - {1'b0, cur};
        w_neg  = w_diff[POS_W];
        w_mag  = w_neg ? (~w_diff + (POS_W+1)'(1)) : w_diff;
        next   = target;
        if (w_mag > {1'b0, step}) begin
            next = w_neg ? (cur - step) : (cur + step);
        end
    end

endmodule

// File: rtl/servo_pwm_slew.sv
// Frame-based servo PWM generator with optional per-frame position slew.
// Optional feature macro: SERVO_SLEW_EN (slew limiting on the driven position).
module servo_pwm_slew
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES      = FRAME_CYCLES_DEF,
    parameter int unsigned PULSE_MIN_CYCLES  = PULSE_MIN_DEF,
    parameter int unsigned PULSE_STEP_CYCLES = PULSE_STEP_DEF,
    parameter int unsigned SLEW_STEP         = SLEW_STEP_DEF,
    parameter int unsigned RESET_POS         = RESET_POS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [POS_W-1:0] position,
    output logic             pwm_out,
    output logic             frame_start,
    output logic [POS_W-1:0] cur_position,
    output logic             at_target
);

    localparam int unsigned CNT_W   = $clog2(FRAME_CYCLES);
    localparam int unsigned LEN_MAX = PULSE_MIN_CYCLES + 255 * PULSE_STEP_CYCLES;
    localparam int unsigned LEN_W   = $clog2(LEN_MAX + 1);

    servo_state_e     r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [LEN_W-1:0] r_pulse_len, w_len_nxt;
    logic             r_pwm, w_pwm_nxt;
    logic             r_fs, w_fs_nxt;
    logic             r_at, w_at_nxt;
    logic [POS_W-1:0] r_target, w_target_nxt;
    logic [POS_W-1:0] r_cur, w_cur_nxt;
    logic [POS_W-1:0] w_slew_cur;
    logic             w_start;

`ifdef SERVO_SLEW_EN
    servo_slew_limiter u_slew (
        .cur    (r_cur),
        .target (position),
        .step   (POS_W'(SLEW_STEP)),
        .next   (w_slew_cur)
    );
`else
    assign w_slew_cur = position;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pulse_len <= '0;
            r_pwm       <= 1'b0;
            r_fs        <= 1'b0;
            r_at        <= 1'b0;
            r_target    <= POS_W'(RESET_POS);
            r_cur       <= POS_W'(RESET_POS);
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pulse_len <= w_len_nxt;
            r_pwm       <= w_pwm_nxt;
            r_fs        <= w_fs_nxt;
            r_at        <= w_at_nxt;
            r_target    <= w_target_nxt;
            r_cur       <= w_cur_nxt;
        end
    end

    // Enable is only looked at in idle or on the last cycle of a frame.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_len_nxt    = r_pulse_len;
        w_pwm_nxt    = 1'b0;
        w_fs_nxt     = 1'b0;
        w_at_nxt     = r_at;
        w_target_nxt = r_target;
        w_cur_nxt    = r_cur;
        w_start      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_at_nxt  = 1'b0;
                w_start   = enable;
            end
            ST_RUN: begin
                w_pwm_nxt = (32'(r_cnt) < 32'(r_pulse_len));
                if (r_fs) begin
                    w_at_nxt = (r_cur == r_target);
                end
                if (32'(r_cnt) == FRAME_CYCLES - 1) begin
                    w_cnt_nxt = '0;
                    if (enable) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_at_nxt    = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_start) begin
            w_state_nxt  = ST_RUN;
            w_fs_nxt     = 1'b1;
            w_target_nxt = position;
            w_cur_nxt    = w_slew_cur;
            w_len_nxt    = LEN_W'(pulse_len(w_slew_cur, PULSE_MIN_CYCLES, PULSE_STEP_CYCLES));
        end
    end

    assign pwm_out      = r_pwm;
    assign frame_start  = r_fs;
    assign cur_position = r_cur;
    assign at_target    = r_at;

endmodule

// File: tb/tb_servo_pwm_slew.sv
// Directed bench for servo_pwm_slew with shortened frame timing; honours SERVO_SLEW_EN.
module tb_servo_pwm_slew;

    localparam int unsigned FRAME = 400;
    localparam int unsigned PMIN  = 20;
    localparam int unsigned PSTEP = 1;
    localparam int unsigned SLEW  = 4;
    localparam int unsigned RPOS  = 128;

`ifdef SERVO_SLEW_EN
    localparam logic [7:0] EXP_POST_RST = 8'd132;
`else
    localparam logic [7:0] EXP_POST_RST = 8'd139;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] position;
    logic       pwm_out;
    logic       frame_start;
    logic [7:0] cur_position;
    logic       at_target;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    servo_pwm_slew #(
        .FRAME_CYCLES      (FRAME),
        .PULSE_MIN_CYCLES  (PMIN),
        .PULSE_STEP_CYCLES (PSTEP),
        .SLEW_STEP         (SLEW),
        .RESET_POS         (RPOS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .position     (position),
        .pwm_out      (pwm_out),
        .frame_start  (frame_start),
        .cur_position (cur_position),
        .at_target    (at_target)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] pos;
        logic [7:0] cur_off;
        logic [7:0] cur_on;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pick(input vec_t v);
`ifdef SERVO_SLEW_EN
        return v.cur_on;
`else
        return v.cur_off;
`endif
    endfunction

    task automatic wait_fs(input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2 * int'(FRAME); n++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, " frame_start timeout"}, 32'd0, 32'd1);
    endtask

    // Called on the negedge of a frame_start cycle; returns on the frame's last cycle.
    task automatic run_frame(input string tag, input logic [7:0] exp_cur, input logic [7:0] tgt,
                             input int drop_en_at, input logic [7:0] next_pos);
        int len;
        int cnt;
        int first;
        int last;
        len   = int'(PMIN) + int'(exp_cur) * int'(PSTEP);
        cnt   = 0;
        first = 0;
        last  = 0;
        check({tag, " cur_position"}, 32'(cur_position), 32'(exp_cur));
        for (int j = 1; j < int'(FRAME); j++) begin
            @(negedge clk);
            if (j == 1) check({tag, " at_target"}, 32'(at_target), 32'(exp_cur == tgt));
            if (j == 10) position = next_pos;
            if (j == drop_en_at) enable = 1'b0;
            if (pwm_out === 1'b1) begin
                cnt++;
                if (first == 0) first = j;
                last = j;
            end
            if (frame_start !== 1'b0) check({tag, " stray frame_start"}, 32'(frame_start), 32'd0);
        end
        check({tag, " pulse len"}, 32'(cnt), 32'(len));
        check({tag, " pulse window"}, 32'(first == 1 && last == len), 32'd1);
    endtask

    initial begin
        bit ok;
        int t_prev;
        int acc;

        vecs[0] = '{pos: 8'd0,   cur_off: 8'd0,   cur_on: 8'd124};
        vecs[1] = '{pos: 8'd0,   cur_off: 8'd0,   cur_on: 8'd120};
        vecs[2] = '{pos: 8'd255, cur_off: 8'd255, cur_on: 8'd124};
        vecs[3] = '{pos: 8'd200, cur_off: 8'd200, cur_on: 8'd128};
        vecs[4] = '{pos: 8'd140, cur_off: 8'd140, cur_on: 8'd132};
        vecs[5] = '{pos: 8'd140, cur_off: 8'd140, cur_on: 8'd136};
        vecs[6] = '{pos: 8'd140, cur_off: 8'd140, cur_on: 8'd140};
        vecs[7] = '{pos: 8'd138, cur_off: 8'd138, cur_on: 8'd138};
        vecs[8] = '{pos: 8'd139, cur_off: 8'd139, cur_on: 8'd139};

        reset    = 1'b1;
        enable   = 1'b0;
        position = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset pwm_out", 32'(pwm_out), 32'd0);
        check("reset frame_start", 32'(frame_start), 32'd0);
        check("reset at_target", 32'(at_target), 32'd0);
        check("reset cur_position", 32'(cur_position), 32'(RPOS));

        reset = 1'b0;
        acc   = 0;
        repeat (6) begin
            @(negedge clk);
            acc += int'(frame_start) + int'(pwm_out) + int'(at_target);
        end
        check("idle outputs quiet", 32'(acc), 32'd0);

        position = vecs[0].pos;
        enable   = 1'b1;
        @(negedge clk);
        check("start one cycle after enable", 32'(frame_start), 32'd1);
        t_prev = cyc;

        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                wait_fs($sformatf("vec%0d", i), ok);
                if (!ok) break;
                check($sformatf("vec%0d frame period", i), 32'(cyc - t_prev), 32'(FRAME));
                t_prev = cyc;
            end
            run_frame($sformatf("vec%0d", i), pick(vecs[i]), vecs[i].pos, -1,
                      (i < 8) ? vecs[i + 1].pos : 8'd139);
        end

        // Enable dropped mid-pulse: the pulse completes, then the block idles.
        wait_fs("drop", ok);
        if (ok) run_frame("drop", 8'd139, 8'd139, 50, 8'd139);
        acc = 0;
        for (int n = 0; n < 2 * int'(FRAME); n++) begin
            @(negedge clk);
            acc += int'(frame_start) + int'(pwm_out);
        end
        check("idle after disable", 32'(acc), 32'd0);
        check("idle at_target", 32'(at_target), 32'd0);

        // Restart, then reset in the middle of the pulse.
        enable = 1'b1;
        @(negedge clk);
        check("restart frame_start", 32'(frame_start), 32'd1);
        for (int j = 1; j <= 30; j++) @(negedge clk);
        check("mid pulse pwm high", 32'(pwm_out), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("reset mid pulse pwm_out", 32'(pwm_out), 32'd0);
        check("reset mid pulse cur_position", 32'(cur_position), 32'(RPOS));
        check("reset mid pulse frame_start", 32'(frame_start), 32'd0);
        check("reset mid pulse at_target", 32'(at_target), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("frame after reset release", 32'(frame_start), 32'd1);
        run_frame("post-reset", EXP_POST_RST, 8'd139, -1, 8'd139);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
